// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage access unit: op encodings, FSM states
// and small decode helpers used by the unit and its lane aligner.
package mem_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= MEM_LB) && (op <= MEM_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= MEM_SB) && (op <= MEM_SW);
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return lo[0];
      MEM_LW, MEM_SW:          return lo != 2'b00;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane logic: positions store data/enables on the bus and extracts,
// then sign- or zero-extends, load data from the returned word.
module mem_align import mem_pkg::*; (
  input  logic [3:0]  st_op,
  input  logic [1:0]  st_lo,
  input  logic [31:0] sdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [3:0]  ld_op,
  input  logic [1:0]  ld_lo,
  input  logic [31:0] rdata,
  output logic [31:0] ldata
);

  logic [31:0] shifted;

  always_comb begin
    be    = 4'b1111;
    wdata = sdata;
    case (st_op)
      MEM_SB: begin
        be    = 4'b0001 << st_lo;
        wdata = {4{sdata[7:0]}};
      end
      MEM_SH: begin
        be    = st_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{sdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Bring the addressed lane down to bit 0 before extension.
  always_comb begin
    shifted = rdata >> {ld_lo, 3'b000};
    case (ld_op)
      MEM_LB:  ldata = {{24{shifted[7]}}, shifted[7:0]};
      MEM_LBU: ldata = {24'h0, shifted[7:0]};
      MEM_LH:  ldata = {{16{shifted[15]}}, shifted[15:0]};
      MEM_LHU: ldata = {16'h0, shifted[15:0]};
      default: ldata = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: issues req/ack bus transactions for
// loads/stores, stalls upstream while busy, and drives MEM/WB outputs.
module mem_access_unit import mem_pkg::*; #(
  parameter int TIMEOUT = 256,
  parameter int TO_W    = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_we,
  input  logic [4:0]  mem_waddr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  output logic        stall_req,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        wb_we,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  state_e      state, next_state;
  logic [TO_W-1:0] cnt;
  logic [3:0]  cap_op;
  logic [1:0]  cap_lo;
  logic [4:0]  cap_waddr;
  logic        cap_we;
  logic [31:0] cap_wdata;
  logic        issue_mem, issue_bad, issue_go, timed_out;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;

  assign issue_mem = is_load(mem_op) || is_store(mem_op);
  assign issue_bad = issue_mem && is_misaligned(mem_op, mem_addr[1:0]);
  assign issue_go  = issue_mem && !issue_bad;
  assign timed_out = (TIMEOUT != 0) && (cnt == TO_LAST);

  mem_align u_align (
    .st_op (mem_op),
    .st_lo (mem_addr[1:0]),
    .sdata (mem_sdata),
    .be    (st_be),
    .wdata (st_wdata),
    .ld_op (cap_op),
    .ld_lo (cap_lo),
    .rdata (bus_rdata),
    .ldata (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (issue_go) next_state = ST_BUSY;
      ST_BUSY: if (bus_ack || timed_out) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_req = 1'b0;
    case (state)
      ST_IDLE: stall_req = issue_go;
      ST_BUSY: stall_req = !bus_ack;
      default: stall_req = 1'b0;
    endcase
  end

  // Error pulses and wb_we default low; each state only raises what it needs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req      <= 1'b0;
      bus_wr       <= 1'b0;
      bus_addr     <= '0;
      bus_be       <= '0;
      bus_wdata    <= '0;
      wb_we        <= 1'b0;
      wb_waddr     <= '0;
      wb_wdata     <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      cnt          <= '0;
      cap_op       <= '0;
      cap_lo       <= '0;
      cap_waddr    <= '0;
      cap_we       <= 1'b0;
      cap_wdata    <= '0;
    end else begin
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      wb_we        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue_bad) begin
            misalign_err <= 1'b1;
          end else if (issue_go) begin
            bus_req   <= 1'b1;
            bus_wr    <= is_store(mem_op);
            bus_addr  <= {mem_addr[31:2], 2'b00};
            bus_be    <= st_be;
            bus_wdata <= st_wdata;
            cap_op    <= mem_op;
            cap_lo    <= mem_addr[1:0];
            cap_waddr <= mem_waddr;
            cap_we    <= mem_we;
            cap_wdata <= mem_wdata;
            cnt       <= '0;
          end else begin
            wb_we    <= mem_we;
            wb_waddr <= mem_waddr;
            wb_wdata <= mem_wdata;
          end
        end
        ST_BUSY: begin
          if (bus_ack) begin
            bus_req  <= 1'b0;
            wb_waddr <= cap_waddr;
            if (is_load(cap_op)) begin
              wb_we    <= 1'b1;
              wb_wdata <= ld_data;
            end else begin
              wb_we    <= cap_we;
              wb_wdata <= cap_wdata;
            end
          end else if (timed_out) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a scoreboard queue of expected
// write-backs plus per-scenario checks of bus, stall and error behaviour.
module tb_mem_access_unit;

  localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3,
                         OP_LHU = 4'd4, OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_sdata;
  logic        stall_req;
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        misalign_err;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_exp_t;

  wb_exp_t sb[$];
  wb_exp_t e;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
    logic [4:0]  waddr;
    logic [3:0]  delay;
  } ld_case_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] bwdata;
  } st_case_t;

  mem_access_unit #(.TIMEOUT(4), .TO_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_op       (mem_op),
    .mem_addr     (mem_addr),
    .mem_sdata    (mem_sdata),
    .stall_req    (stall_req),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_addr     (bus_addr),
    .bus_be       (bus_be),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack),
    .wb_we        (wb_we),
    .wb_waddr     (wb_waddr),
    .wb_wdata     (wb_wdata),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic we, input logic [4:0] waddr, input logic [31:0] wdata);
    mem_op    = op;
    mem_addr  = addr;
    mem_sdata = sdata;
    mem_we    = we;
    mem_waddr = waddr;
    mem_wdata = wdata;
  endtask

  task automatic idle_inputs();
    drive(OP_NONE, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_ack = 1'b0;
    bus_rdata = 32'h0;
    idle_inputs();
    step();
    step();
    total++;
    if ({bus_req, bus_wr, bus_be, wb_we, misalign_err, bus_err} !== 9'b0) begin
      bad++;
      $display("[TB] FAIL reset ctrl: got %b expected 0",
               {bus_req, bus_wr, bus_be, wb_we, misalign_err, bus_err});
    end
    total++;
    if ({bus_addr, bus_wdata} !== 64'h0) begin
      bad++;
      $display("[TB] FAIL reset bus: got %h expected 0", {bus_addr, bus_wdata});
    end
    total++;
    if ({wb_waddr, wb_wdata} !== 37'h0) begin
      bad++;
      $display("[TB] FAIL reset wb: got %h expected 0", {wb_waddr, wb_wdata});
    end
    rst = 1'b0;
    #1;
    total++;
    if (stall_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset stall: got %b expected 0", stall_req);
    end
  endtask

  task automatic test_none();
    drive(OP_NONE, 32'h40, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
    sb.push_back('{5'd5, 32'hDEADBEEF});
    #1;
    total++;
    if (stall_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL none stall: got %b expected 0", stall_req);
    end
    step();
    idle_inputs();
    total++;
    if (wb_we !== 1'b1) begin
      bad++;
      $display("[TB] FAIL none wb_we: got %b expected 1", wb_we);
    end else if (sb.size() == 0) begin
      bad++;
      $display("[TB] FAIL none scoreboard: got empty expected entry");
    end else begin
      e = sb.pop_front();
      if ({wb_waddr, wb_wdata} !== {e.waddr, e.wdata}) begin
        bad++;
        $display("[TB] FAIL none wb data: got %h/%h expected %h/%h", wb_waddr, wb_wdata, e.waddr, e.wdata);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      drive((i == 2) ? 4'd12 : OP_NONE, 32'h0, 32'h0, (i != 3), 5'(10 + i), d);
      if (i != 3) sb.push_back('{5'(10 + i), d});
      #1;
      total++;
      if (stall_req !== 1'b0) begin
        bad++;
        $display("[TB] FAIL b2b%0d stall: got %b expected 0", i, stall_req);
      end
      step();
      total++;
      if (wb_we !== (i != 3)) begin
        bad++;
        $display("[TB] FAIL b2b%0d wb_we: got %b expected %b", i, wb_we, (i != 3));
      end else if (wb_we === 1'b1) begin
        if (sb.size() == 0) begin
          bad++;
          $display("[TB] FAIL b2b%0d scoreboard: got empty expected entry", i);
        end else begin
          e = sb.pop_front();
          if ({wb_waddr, wb_wdata} !== {e.waddr, e.wdata}) begin
            bad++;
            $display("[TB] FAIL b2b%0d wb data: got %h/%h expected %h/%h", i, wb_waddr, wb_wdata, e.waddr, e.wdata);
          end
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_loads();
    ld_case_t lc [6];
    int stalls;
    lc[0] = '{OP_LW,  32'h100, 32'h12345678, 32'h12345678, 5'd1, 4'd3};
    lc[1] = '{OP_LB,  32'h103, 32'h80FFFFFF, 32'hFFFFFF80, 5'd2, 4'd1};
    lc[2] = '{OP_LBU, 32'h103, 32'h80FFFFFF, 32'h00000080, 5'd3, 4'd0};
    lc[3] = '{OP_LHU, 32'h102, 32'hBEEF0000, 32'h0000BEEF, 5'd4, 4'd2};
    lc[4] = '{OP_LH,  32'h100, 32'h12348001, 32'hFFFF8001, 5'd6, 4'd1};
    lc[5] = '{OP_LB,  32'h101, 32'h00007F00, 32'h0000007F, 5'd8, 4'd0};
    for (int i = 0; i < 6; i++) begin
      stalls = 0;
      drive(lc[i].op, lc[i].addr, 32'hFFFFFFFF, 1'b1, lc[i].waddr, 32'h00000BAD);
      sb.push_back('{lc[i].waddr, lc[i].exp});
      #1;
      if (stall_req === 1'b1) stalls++;
      step();
      total++;
      if ({bus_req, bus_wr, bus_be, wb_we} !== 7'b1011110) begin
        bad++;
        $display("[TB] FAIL load%0d issue: got req/wr/be/we=%b expected 1011110", i, {bus_req, bus_wr, bus_be, wb_we});
      end
      total++;
      if (bus_addr !== (lc[i].addr & 32'hFFFFFFFC)) begin
        bad++;
        $display("[TB] FAIL load%0d bus_addr: got %h expected %h", i, bus_addr, lc[i].addr & 32'hFFFFFFFC);
      end
      for (int k = 0; k < int'(lc[i].delay); k++) begin
        if (stall_req === 1'b1) stalls++;
        step();
      end
      bus_ack = 1'b1;
      bus_rdata = lc[i].rdata;
      #1;
      total++;
      if (stall_req !== 1'b0) begin
        bad++;
        $display("[TB] FAIL load%0d ack stall: got %b expected 0", i, stall_req);
      end
      step();
      bus_ack = 1'b0;
      bus_rdata = $urandom;
      idle_inputs();
      total++;
      if (stalls != int'(lc[i].delay) + 1) begin
        bad++;
        $display("[TB] FAIL load%0d stall cycles: got %0d expected %0d", i, stalls, int'(lc[i].delay) + 1);
      end
      total++;
      if (bus_req !== 1'b0 || wb_we !== 1'b1) begin
        bad++;
        $display("[TB] FAIL load%0d complete: got req/we=%b%b expected 01", i, bus_req, wb_we);
      end else if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL load%0d scoreboard: got empty expected entry", i);
      end else begin
        e = sb.pop_front();
        if ({wb_waddr, wb_wdata} !== {e.waddr, e.wdata}) begin
          bad++;
          $display("[TB] FAIL load%0d wb data: got %h/%h expected %h/%h", i, wb_waddr, wb_wdata, e.waddr, e.wdata);
        end
      end
    end
  endtask

  task automatic test_stores();
    st_case_t sc [4];
    sc[0] = '{OP_SB, 32'h201, 32'h000000AB, 1'b0, 5'd0, 32'h0,  4'b0010, 32'hABABABAB};
    sc[1] = '{OP_SH, 32'h202, 32'h00001234, 1'b1, 5'd7, 32'h55, 4'b1100, 32'h12341234};
    sc[2] = '{OP_SW, 32'h204, 32'hCAFEF00D, 1'b0, 5'd0, 32'h0,  4'b1111, 32'hCAFEF00D};
    sc[3] = '{OP_SB, 32'h203, 32'h111111CD, 1'b0, 5'd0, 32'h0,  4'b1000, 32'hCDCDCDCD};
    for (int i = 0; i < 4; i++) begin
      drive(sc[i].op, sc[i].addr, sc[i].sdata, sc[i].we, sc[i].waddr, sc[i].wdata);
      if (sc[i].we) sb.push_back('{sc[i].waddr, sc[i].wdata});
      #1;
      total++;
      if (stall_req !== 1'b1) begin
        bad++;
        $display("[TB] FAIL store%0d stall: got %b expected 1", i, stall_req);
      end
      step();
      step();
      total++;
      if ({bus_req, bus_wr, bus_be} !== {2'b11, sc[i].be}) begin
        bad++;
        $display("[TB] FAIL store%0d req/wr/be: got %b expected %b", i, {bus_req, bus_wr, bus_be}, {2'b11, sc[i].be});
      end
      total++;
      if ({bus_addr, bus_wdata} !== {sc[i].addr & 32'hFFFFFFFC, sc[i].bwdata}) begin
        bad++;
        $display("[TB] FAIL store%0d addr/wdata: got %h/%h expected %h/%h", i, bus_addr, bus_wdata,
                 sc[i].addr & 32'hFFFFFFFC, sc[i].bwdata);
      end
      bus_ack = 1'b1;
      step();
      bus_ack = 1'b0;
      idle_inputs();
      total++;
      if (bus_req !== 1'b0 || wb_we !== sc[i].we) begin
        bad++;
        $display("[TB] FAIL store%0d complete: got req/we=%b%b expected 0%b", i, bus_req, wb_we, sc[i].we);
      end else if (wb_we === 1'b1) begin
        if (sb.size() == 0) begin
          bad++;
          $display("[TB] FAIL store%0d scoreboard: got empty expected entry", i);
        end else begin
          e = sb.pop_front();
          if ({wb_waddr, wb_wdata} !== {e.waddr, e.wdata}) begin
            bad++;
            $display("[TB] FAIL store%0d wb data: got %h/%h expected %h/%h", i, wb_waddr, wb_wdata, e.waddr, e.wdata);
          end
        end
      end
    end
  endtask

  task automatic test_misalign();
    logic [3:0]  ops   [4];
    logic [31:0] addrs [4];
    ops = '{OP_LW, OP_LH, OP_SW, OP_SH};
    addrs = '{32'h101, 32'h103, 32'h202, 32'h205};
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], addrs[i], 32'h5A5A5A5A, 1'b1, 5'd3, 32'h1);
      #1;
      total++;
      if (stall_req !== 1'b0) begin
        bad++;
        $display("[TB] FAIL misalign%0d stall: got %b expected 0", i, stall_req);
      end
      step();
      idle_inputs();
      total++;
      if ({misalign_err, bus_req, wb_we} !== 3'b100) begin
        bad++;
        $display("[TB] FAIL misalign%0d pulse: got err/req/we=%b expected 100", i, {misalign_err, bus_req, wb_we});
      end
      step();
      total++;
      if (misalign_err !== 1'b0) begin
        bad++;
        $display("[TB] FAIL misalign%0d clear: got %b expected 0", i, misalign_err);
      end
    end
  endtask

  task automatic test_timeout();
    int busy = 0;
    logic seen = 1'b0;
    logic wrote = 1'b0;
    drive(OP_LW, 32'h400, 32'h0, 1'b1, 5'd9, 32'h0);
    step();
    for (int n = 0; n < 12 && !seen; n++) begin
      if (wb_we === 1'b1) wrote = 1'b1;
      if (bus_err === 1'b1) seen = 1'b1;
      else begin
        if (bus_req === 1'b1) busy++;
        step();
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL timeout bus_err: got none within 12 cycles expected pulse");
    end
    total++;
    if (busy != 4 || bus_req !== 1'b0 || wrote) begin
      bad++;
      $display("[TB] FAIL timeout busy: got busy=%0d req=%b wrote=%b expected 4/0/0", busy, bus_req, wrote);
    end
    idle_inputs();
    #1;
    total++;
    if (stall_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL timeout stall: got %b expected 0", stall_req);
    end
    step();
    total++;
    if ({bus_err, bus_req} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL timeout clear: got err/req=%b expected 00", {bus_err, bus_req});
    end
  endtask

  task automatic test_reset_busy();
    drive(OP_LW, 32'h300, 32'h0, 1'b1, 5'd11, 32'h0);
    step();
    total++;
    if (bus_req !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rstbusy issue: got %b expected 1", bus_req);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    total++;
    if ({bus_req, bus_be, bus_addr, wb_we} !== 38'h0) begin
      bad++;
      $display("[TB] FAIL rstbusy reset: got %h expected 0", {bus_req, bus_be, bus_addr, wb_we});
    end
    bus_ack = 1'b1;
    bus_rdata = 32'h00000077;
    #1;
    total++;
    if (stall_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rstbusy ack stall: got %b expected 0", stall_req);
    end
    step();
    bus_ack = 1'b0;
    total++;
    if ({wb_we, bus_req, bus_err, misalign_err} !== 4'b0) begin
      bad++;
      $display("[TB] FAIL rstbusy stray ack: got we/req/err/mis=%b expected 0000", {wb_we, bus_req, bus_err, misalign_err});
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_none();
    test_back_to_back();
    test_loads();
    test_stores();
    test_misalign();
    test_timeout();
    test_reset_busy();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard drain: got %0d left expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
